// File: rtl/periph_arb_pkg.sv
// periph_arb_pkg: shared state encoding and master indices for the peripheral bus arbiter
package periph_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, RESP, TOERR} arb_state_e;
  localparam int NUM_MASTERS = 2;
  localparam logic MST_CORE = 1'b0;
  localparam logic MST_DBG = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick favouring the master not served last
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       idx_o,
  output logic       valid_o
);
  assign valid_o = |req_i;
  assign idx_o = &req_i ? ~last_i : req_i[1];
endmodule

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master round-robin arbiter with one outstanding transaction and a stall watchdog
module periph_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       m_req,
  input  logic [1:0]       m_we,
  input  logic [1:0][3:0]  m_be,
  input  logic [1:0][31:0] m_addr,
  input  logic [1:0][31:0] m_wdata,
  output logic [1:0]       m_gnt,
  output logic [1:0]       m_rvalid,
  output logic [31:0]      m_rdata,
  output logic [1:0]       m_err,
  output logic             s_req,
  output logic             s_we,
  output logic [3:0]       s_be,
  output logic [31:0]      s_addr,
  output logic [31:0]      s_wdata,
  input  logic             s_gnt,
  input  logic             s_rvalid,
  input  logic             s_err,
  input  logic [31:0]      s_rdata
);
  import periph_arb_pkg::*;
  arb_state_e state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, pick_idx, pick_vld, term;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rr_arb2 u_rr (.req_i(m_req), .last_i(last_q), .idx_o(pick_idx), .valid_o(pick_vld));
  assign term = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= MST_CORE;
      last_q <= MST_DBG;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    cnt_d = '0;
    s_req = 1'b0;
    s_we = 1'b0;
    s_be = '0;
    s_addr = '0;
    s_wdata = '0;
    m_gnt = '0;
    m_rvalid = '0;
    m_err = '0;
    m_rdata = '0;
    case (state_q)
      IDLE: begin
        owner_d = pick_vld ? pick_idx : owner_q;
        state_d = pick_vld ? ADDR : IDLE;
      end
      ADDR: begin
        // at terminal count without a grant, withdraw the request and fake a grant so the master moves on
        s_req = s_gnt | ~term;
        s_we = m_we[owner_q];
        s_be = m_be[owner_q];
        s_addr = m_addr[owner_q];
        s_wdata = m_wdata[owner_q];
        m_gnt[owner_q] = s_gnt | term;
        cnt_d = (s_gnt | term) ? '0 : cnt_q + 1'b1;
        last_d = (s_gnt | term) ? owner_q : last_q;
        state_d = s_gnt ? RESP : term ? TOERR : ADDR;
      end
      RESP: begin
        m_rvalid[owner_q] = s_rvalid;
        m_err[owner_q] = s_rvalid & s_err;
        m_rdata = s_rvalid ? s_rdata : '0;
        cnt_d = cnt_q + 1'b1;
        state_d = s_rvalid ? IDLE : term ? TOERR : RESP;
      end
      TOERR: begin
        m_rvalid[owner_q] = 1'b1;
        m_err[owner_q] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
